// File: rtl/pcileech_tlp_arb_pkg.sv
// Shared types and helpers for the TLP TX arbiter.
// rr_pick implements the round-robin search used at each packet boundary.
package pcileech_tlp_arb_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_t;

  // Widest source set the helper supports; callers zero-extend their request vector.
  localparam int MAX_SRC = 8;
  localparam int SEL_W   = 3;

  // Winner is the first requester found searching upward from ptr+1, wrapping at n.
  // The loop runs from the far end back toward ptr+1 so the closest hit is written last.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0] req,
    input logic [SEL_W-1:0]   ptr,
    input int                 n
  );
    logic [SEL_W-1:0] win;
    int               idx;
    win = 3'd0;
    idx = 0;
    for (int k = MAX_SRC; k > 0; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[SEL_W-1:0]]) begin
          win = idx[SEL_W-1:0];
        end else begin
          win = win;
        end
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/pcileech_axis_skid64.sv
// Two-entry data/keep/last buffer with ready/valid on both sides.
// The core-facing outputs come straight from the head register, and the
// upstream ready depends only on occupancy, so neither side sees a combinational
// path through this block.
module pcileech_axis_skid64 #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [KEEP_W-1:0] in_keep_i,
  input  logic              in_last_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [KEEP_W-1:0] out_keep_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [KEEP_W-1:0] head_keep_q, head_keep_d, tail_keep_q, tail_keep_d;
  logic              head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic              push_s, pop_s;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_data_q;
  assign out_keep_o  = head_keep_q;
  assign out_last_o  = head_last_q;
  assign push_s      = in_valid_i & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_i;

  // Entry update: head always holds the oldest beat, tail only used when two are held.
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_keep_d = head_keep_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_keep_d = tail_keep_q;
    tail_last_d = tail_last_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_data_d = in_data_i;
          head_keep_d = in_keep_i;
          head_last_d = in_last_i;
          cnt_d       = 2'd1;
        end else begin
          tail_data_d = in_data_i;
          tail_keep_d = in_keep_i;
          tail_last_d = in_last_i;
          cnt_d       = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_keep_d = tail_keep_q;
          head_last_d = tail_last_q;
          cnt_d       = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'b11: begin
        // Push and pop together can only happen with exactly one entry held.
        head_data_d = in_data_i;
        head_keep_d = in_keep_i;
        head_last_d = in_last_i;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Buffer registers, cleared to an empty zeroed state on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_keep_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_keep_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_keep_q <= head_keep_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_keep_q <= tail_keep_d;
      tail_last_q <= tail_last_d;
    end
  end

endmodule

// File: rtl/pcileech_tlps64_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the PCIe core TX stream.
// A source keeps the grant for a whole TLP; a per-packet beat limit forces
// release of runaway packets. Output path is registered through a 2-entry skid.
module pcileech_tlps64_tx_arbiter
  import pcileech_tlp_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 64,
  localparam int KEEP_W   = DATA_W / 8,
  localparam int IDX_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        tx_en,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC*KEEP_W-1:0] s_keep,
  input  logic [NUM_SRC-1:0]        s_last,
  input  logic [NUM_SRC-1:0]        s_valid,
  output logic [NUM_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [KEEP_W-1:0]         m_keep,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      err_len,
  output logic                      err_keep
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_len_q, err_len_d;
  logic               err_keep_q, err_keep_d;

  logic [NUM_SRC-1:0] req_s;
  logic [MAX_SRC-1:0] req_ext_s;
  logic [IDX_W-1:0]   pick_s;
  logic [DATA_W-1:0]  src_data_s;
  logic [KEEP_W-1:0]  src_keep_s;
  logic               src_last_s;
  logic               src_valid_s;
  logic               skid_in_ready_s;
  logic               acc_s;
  logic               cap_s;

  assign req_s     = s_valid & tx_en;
  assign req_ext_s = MAX_SRC'(req_s);
  assign pick_s    = IDX_W'(rr_pick(req_ext_s, SEL_W'(rr_ptr_q), NUM_SRC));

  // The granted source drives the skid input; the mux is static between grants.
  assign src_data_s  = s_data[int'(grant_q) * DATA_W +: DATA_W];
  assign src_keep_s  = s_keep[int'(grant_q) * KEEP_W +: KEEP_W];
  assign src_last_s  = s_last[grant_q];
  assign src_valid_s = s_valid[grant_q];

  assign acc_s = (state_q == S_BUSY) & src_valid_s & skid_in_ready_s;
  // Beat that reaches the limit without its own last gets cut here.
  assign cap_s = ~src_last_s & (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  // Only the granted source sees ready, and only while a packet is open.
  always_comb begin
    s_ready = '0;
    if (state_q == S_BUSY) begin
      s_ready[grant_q] = skid_in_ready_s;
    end else begin
      s_ready = '0;
    end
  end

  // Arbitration and packet tracking next-state.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_len_d  = err_len_q;
    err_keep_d = err_keep_q;
    case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        if (|req_s) begin
          grant_d  = pick_s;
          rr_ptr_d = pick_s;
          state_d  = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (acc_s) begin
          if (!src_last_s && (src_keep_s != {KEEP_W{1'b1}})) begin
            err_keep_d = 1'b1;
          end else begin
            err_keep_d = err_keep_q;
          end
          if (src_last_s) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
          end else if (cap_s) begin
            err_len_d  = 1'b1;
            state_d    = S_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Arbiter state registers; rr pointer starts at the top so source 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
      err_keep_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_len_q  <= err_len_d;
      err_keep_q <= err_keep_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == S_BUSY);
  assign err_len   = err_len_q;
  assign err_keep  = err_keep_q;

  pcileech_axis_skid64 #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (src_data_s),
    .in_keep_i   (src_keep_s),
    .in_last_i   (src_last_s | cap_s),
    .in_valid_i  (acc_s),
    .in_ready_o  (skid_in_ready_s),
    .out_data_o  (m_data),
    .out_keep_o  (m_keep),
    .out_last_o  (m_last),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready)
  );

endmodule

// File: tb/tb_pcileech_tlps64_tx_arbiter.sv
// Self-checking bench for the TLP TX arbiter. Sources are queues of beats;
// the expected core-side stream is derived packet by packet from the
// round-robin rule and the beat limit.
module tb_pcileech_tlps64_tx_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     tx_en;
  logic [NS*DW-1:0]  s_data;
  logic [NS*KW-1:0]  s_keep;
  logic [NS-1:0]     s_last, s_valid, s_ready;
  logic [DW-1:0]     m_data;
  logic [KW-1:0]     m_keep;
  logic              m_last, m_valid, m_ready;
  logic [1:0]        grant_idx;
  logic              busy, err_len, err_keep;

  always #5 clk = ~clk;

  pcileech_tlps64_tx_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .grant_idx(grant_idx), .busy(busy), .err_len(err_len), .err_keep(err_keep)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        first;
  } beat_t;

  beat_t      srcq [NS][$];
  beat_t      expq [$];
  int         outcyc [$];
  logic [7:0] outtag [$];
  int total = 0, bad = 0;
  int occ = 0, maxocc = 0, model_ptr = NS - 1, pkt_seq = 0;
  logic exp_err_len = 1'b0, exp_err_keep = 1'b0;

  task automatic do_reset();
    rst_n = 1'b0; m_ready = 1'b0; tx_en = '0;
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    expq.delete();
    occ = 0; maxocc = 0; model_ptr = NS - 1;
    exp_err_len = 1'b0; exp_err_keep = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic gen(input logic [NS-1:0] which, input int npk, input int minlen,
                     input int maxlen, input bit with_last, input int kerr_pct);
    beat_t b;
    int len;
    for (int p = 0; p < npk; p++) begin
      for (int i = 0; i < NS; i++) begin
        if (which[i]) begin
          len = $urandom_range(maxlen, minlen);
          for (int j = 0; j < len; j++) begin
            b.d = {8'(i), 8'(pkt_seq), 8'(j), 8'h00, 32'($urandom())};
            b.l = with_last && (j == len - 1);
            if (b.l) b.k = 8'($urandom_range(255, 1));
            else if (int'($urandom_range(99)) < kerr_pct) b.k = 8'($urandom_range(254, 0));
            else b.k = 8'hff;
            b.first = ((j % MB) == 0);
            srcq[i].push_back(b);
          end
          pkt_seq++;
        end
      end
    end
  endtask

  // Expected output order: each arbitration serves the next enabled source with
  // pending beats after the previous winner; a packet is cut at MB beats.
  task automatic build_model(input logic [NS-1:0] en);
    beat_t mq [NS][$];
    beat_t b;
    int src, cnt, cand;
    bit found, done;
    for (int i = 0; i < NS; i++) mq[i] = srcq[i];
    found = 1'b1;
    while (found) begin
      found = 1'b0; src = 0;
      for (int k = 1; k <= NS; k++) begin
        cand = (model_ptr + k) % NS;
        if (!found && en[cand] && mq[cand].size() > 0) begin
          found = 1'b1; src = cand;
        end
      end
      if (found) begin
        model_ptr = src; cnt = 0; done = 1'b0;
        while (!done && mq[src].size() > 0) begin
          b = mq[src].pop_front();
          cnt++;
          if (!b.l && b.k != 8'hff) exp_err_keep = 1'b1;
          if (!b.l && cnt == MB) begin b.l = 1'b1; exp_err_len = 1'b1; end
          if (b.l) done = 1'b1;
          expq.push_back(b);
        end
      end
    end
  endtask

  task automatic drive(input logic [NS-1:0] en, input int drop_pct);
    beat_t b;
    tx_en = en;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0) begin
        b = srcq[i][0];
        s_valid[i] = b.first ? 1'b1 : (int'($urandom_range(99)) >= drop_pct);
        s_data[i*DW +: DW] = b.d;
        s_keep[i*KW +: KW] = b.k;
        s_last[i] = b.l;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_keep[i*KW +: KW] = '0;
        s_last[i] = 1'b0;
      end
    end
  endtask

  // rdy_mode: 0 always ready, 1 repeating 1,0,0,1, 2 random 70%.
  task automatic run_traffic(input logic [NS-1:0] en, input int rdy_mode, input int drop_pct,
                             input int budget, input bit mask_chk);
    int n, tail;
    bit stall;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic pl;
    beat_t e, b;
    n = 0; tail = 0; stall = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    outcyc.delete(); outtag.delete();
    while ((expq.size() > 0 || tail < 3) && n < budget) begin
      @(negedge clk);
      n++;
      if (expq.size() == 0) tail++;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ((n % 4) == 1) || ((n % 4) == 0);
        default: m_ready = (int'($urandom_range(99)) < 70);
      endcase
      drive(en, drop_pct);
      total++;
      if (m_valid !== (occ > 0)) begin
        bad++; $display("FAIL m_valid_vs_held got=%b held=%0d cyc=%0d", m_valid, occ, n);
      end
      if (occ == 2) begin
        total++;
        if (s_ready !== '0) begin bad++; $display("FAIL s_ready_full got=%b exp=0000", s_ready); end
      end
      total++;
      if ($countones(s_ready) > 1) begin bad++; $display("FAIL s_ready_onehot got=%b", s_ready); end
      if (mask_chk) begin
        total++;
        if ((s_ready & ~en) !== '0) begin bad++; $display("FAIL masked_ready got=%b en=%b", s_ready, en); end
      end
      if (stall) begin
        total++;
        if ({m_data, m_keep, m_last} !== {pd, pk, pl}) begin
          bad++; $display("FAIL stall_stable got=%h/%h/%b exp=%h/%h/%b", m_data, m_keep, m_last, pd, pk, pl);
        end
      end
      if (m_valid && m_ready) begin
        outcyc.push_back(n);
        outtag.push_back(m_data[63:56]);
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL extra_beat got=%h exp=none", m_data);
        end else begin
          e = expq.pop_front();
          if (m_data !== e.d || m_keep !== e.k || m_last !== e.l) begin
            bad++; $display("FAIL beat got=%h/%h/%b exp=%h/%h/%b", m_data, m_keep, m_last, e.d, e.k, e.l);
          end
        end
        occ--;
      end
      stall = m_valid && !m_ready; pd = m_data; pk = m_keep; pl = m_last;
      for (int i = 0; i < NS; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          b = srcq[i].pop_front();
          occ++;
        end
      end
      if (occ > maxocc) maxocc = occ;
    end
    total++;
    if (expq.size() != 0) begin bad++; $display("FAIL timeout got_left=%0d exp=0", expq.size()); end
    total++;
    if (err_len !== exp_err_len) begin bad++; $display("FAIL err_len got=%b exp=%b", err_len, exp_err_len); end
    total++;
    if (err_keep !== exp_err_keep) begin bad++; $display("FAIL err_keep got=%b exp=%b", err_keep, exp_err_keep); end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({m_valid, m_last, busy, err_len, err_keep} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {m_valid, m_last, busy, err_len, err_keep});
    end
    total++;
    if (m_data !== 64'h0 || m_keep !== 8'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", m_data, m_keep); end
    total++;
    if (s_ready !== 4'b0000 || grant_idx !== 2'd0) begin
      bad++; $display("FAIL reset_ready_grant got=%b/%0d exp=0000/0", s_ready, grant_idx);
    end
  endtask

  task automatic test_single();
    gen(4'b0001, 1, 3, 3, 1'b1, 0);
    build_model(4'b1111);
    run_traffic(4'b1111, 0, 0, 100, 1'b0);
    total++;
    if (outcyc.size() != 3) begin
      bad++; $display("FAIL single_count got=%0d exp=3", outcyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (outcyc[k] != k + 3) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", outcyc[k], k + 3); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    gen(4'b1111, 3, 1, 1, 1'b1, 0);
    build_model(4'b1111);
    run_traffic(4'b1111, 0, 0, 200, 1'b0);
    for (int k = 0; k < outtag.size(); k++) begin
      total++;
      if (outtag[k] != 8'(k % NS)) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", outtag[k], k % NS); end
      if (k > 0) begin
        total++;
        if (outcyc[k] - outcyc[k-1] != 2) begin bad++; $display("FAIL rr_gap got=%0d exp=2", outcyc[k] - outcyc[k-1]); end
      end
    end
  endtask

  task automatic test_mask();
    gen(4'b1111, 3, 1, 1, 1'b1, 0);
    build_model(4'b1010);
    run_traffic(4'b1010, 0, 0, 200, 1'b1);
    total++;
    if (outtag.size() != 6) begin bad++; $display("FAIL mask_count got=%0d exp=6", outtag.size()); end
    for (int k = 0; k < outtag.size(); k++) begin
      total++;
      if (outtag[k] != ((k % 2 == 0) ? 8'd1 : 8'd3)) begin
        bad++; $display("FAIL mask_order got=%0d exp=%0d", outtag[k], (k % 2 == 0) ? 1 : 3);
      end
    end
    srcq[0].delete(); srcq[2].delete();
  endtask

  task automatic test_backpressure();
    maxocc = 0;
    gen(4'b0010, 1, 4, 4, 1'b1, 0);
    build_model(4'b1111);
    run_traffic(4'b1111, 1, 0, 200, 1'b0);
    total++;
    if (maxocc != 2) begin bad++; $display("FAIL bp_fill got=%0d exp=2", maxocc); end
  endtask

  task automatic test_max_beats();
    gen(4'b0100, 1, 6, 6, 1'b0, 0);
    build_model(4'b1111);
    run_traffic(4'b1111, 0, 0, 200, 1'b0);
    total++;
    if (busy !== 1'b1 || grant_idx !== 2'd2) begin
      bad++; $display("FAIL maxb_hold got=%b/%0d exp=1/2", busy, grant_idx);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_valid, busy, err_len} !== 3'b000 || s_ready !== 4'b0000) begin
      bad++; $display("FAIL async_reset got=%b/%b exp=000/0000", {m_valid, busy, err_len}, s_ready);
    end
    do_reset();
    gen(4'b1111, 1, 1, 1, 1'b1, 0);
    build_model(4'b1111);
    run_traffic(4'b1111, 0, 0, 200, 1'b0);
    total++;
    if (outtag.size() == 0 || outtag[0] != 8'd0) begin
      bad++; $display("FAIL post_reset_first got=%0d exp=0", (outtag.size() > 0) ? outtag[0] : 8'hff);
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] en;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      en = 4'($urandom_range(15, 1));
      gen(4'b1111, 3, 1, 7, 1'b1, 15);
      build_model(en);
      run_traffic(en, 2, 20, 3000, 1'b1);
      for (int i = 0; i < NS; i++) if (!en[i]) srcq[i].delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; tx_en = '0;
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_max_beats();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
